// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the run/stop controller: FSM states, completion
// status codes and the default counter width.
package run_ctrl_pkg;

  localparam int CYCLE_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    STAT_RUNNING = 2'b00,
    STAT_HALTED  = 2'b01,
    STAT_TIMEOUT = 2'b10,
    STAT_HANG    = 2'b11
  } status_e;

endpackage

// File: rtl/run_controller_popcount.sv
// commit_popcount: combinational count of asserted commit channels.
module commit_popcount #(
  parameter int NUM_CH = 1
) (
  input  logic [NUM_CH-1:0]            vld,
  output logic [$clog2(NUM_CH+1)-1:0]  cnt
);

  localparam int CNT_W = $clog2(NUM_CH + 1);

  // Sum the individual valid bits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_CH; i++) cnt = cnt + CNT_W'(vld[i]);
  end

endmodule

// File: rtl/run_controller.sv
// run_controller: staged core reset release, run-cycle budget, saturating
// commit counting, halt detection and an optional hang watchdog.
// Optional feature macro: RUN_CTRL_HANG_DET_EN (idle counter + HANG status).
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int CYCLE_W    = CYCLE_W_DEF,
  parameter int MAX_CYCLES = 10,
  parameter int RST_HOLD   = 2,
  parameter int NUM_CH     = 1,
  parameter int IDLE_LIMIT = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_CH-1:0]  commit_valid,
  input  logic               halt_req,
  output logic               core_rstn,
  output logic [CYCLE_W-1:0] cycle_cnt,
  output logic [CYCLE_W-1:0] commit_cnt,
  output logic               done,
  output logic [1:0]         status
);

  localparam int PC_W   = $clog2(NUM_CH + 1);
  localparam int SUM_W  = ((CYCLE_W > PC_W) ? CYCLE_W : PC_W) + 1;
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [CYCLE_W-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  status_e              status_q, status_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [CYCLE_W-1:0]   cycle_q, cycle_d;
  logic [CYCLE_W-1:0]   commit_q, commit_d;
  logic                 done_q, done_d;
  logic                 core_rstn_q, core_rstn_d;
  logic [PC_W-1:0]      pop;
  logic [SUM_W-1:0]     commit_sum;
  logic                 timeout_hit;
  logic                 hang_hit;

  commit_popcount #(.NUM_CH(NUM_CH)) u_popcount (
    .vld (commit_valid),
    .cnt (pop)
  );

`ifdef RUN_CTRL_HANG_DET_EN
  localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;

  // Idle counter: consecutive commit-free RUN cycles, saturating at the limit.
  always_comb begin
    idle_d = idle_q;
    if (state_q == ST_HOLD) begin
      idle_d = '0;
    end else if (state_q == ST_RUN) begin
      if (pop != '0)                            idle_d = '0;
      else if (idle_q != IDLE_W'(IDLE_LIMIT))   idle_d = idle_q + IDLE_W'(1);
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) idle_q <= '0;
    else       idle_q <= idle_d;
  end

  assign hang_hit = (state_q == ST_RUN) && (idle_d == IDLE_W'(IDLE_LIMIT));
`else
  // Without the watchdog a hang is never declared; IDLE_LIMIT has no effect.
  assign hang_hit = (IDLE_LIMIT < 0) && 1'b0;
`endif

  // Next-state, counter and status logic; stop priority halt > timeout > hang.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cycle_d     = cycle_q;
    commit_d    = commit_q;
    done_d      = done_q;
    status_d    = status_q;
    core_rstn_d = core_rstn_q;
    commit_sum  = SUM_W'(commit_q) + SUM_W'(pop);
    timeout_hit = 1'b0;
    case (state_q)
      ST_HOLD: begin
        core_rstn_d = 1'b0;
        if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
          state_d     = ST_RUN;
          core_rstn_d = 1'b1;
          hold_d      = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (cycle_q != CNT_MAX) cycle_d = cycle_q + CYCLE_W'(1);
        commit_d = (commit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : commit_sum[CYCLE_W-1:0];
        timeout_hit = (MAX_CYCLES != 0) && (64'(cycle_d) == 64'(MAX_CYCLES));
        if (halt_req || timeout_hit || hang_hit) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (halt_req)         status_d = STAT_HALTED;
          else if (timeout_hit) status_d = STAT_TIMEOUT;
          else                  status_d = STAT_HANG;
        end
      end
      ST_DONE: ;
      default: state_d = ST_HOLD;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_HOLD;
      status_q    <= STAT_RUNNING;
      hold_q      <= '0;
      cycle_q     <= '0;
      commit_q    <= '0;
      done_q      <= 1'b0;
      core_rstn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      hold_q      <= hold_d;
      cycle_q     <= cycle_d;
      commit_q    <= commit_d;
      done_q      <= done_d;
      core_rstn_q <= core_rstn_d;
    end
  end

  assign core_rstn  = core_rstn_q;
  assign cycle_cnt  = cycle_q;
  assign commit_cnt = commit_q;
  assign done       = done_q;
  assign status     = status_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: three configurations checked every edge against
// a cycle-level reference model, plus a table of end-state vectors and
// directed asynchronous-reset sequences.
module tb_run_controller;

  localparam bit HANG_EN =
`ifdef RUN_CTRL_HANG_DET_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        cv0, h0, h1, h2;
  logic [3:0]  cv1;
  logic [1:0]  cv2;
  logic        cr0, cr1, cr2, d0, d1, d2;
  logic [31:0] cc0, cm0, cc1, cm1;
  logic [3:0]  cc2, cm2;
  logic [1:0]  st0, st1, st2;

  run_controller #(.CYCLE_W(32), .MAX_CYCLES(10), .RST_HOLD(2), .NUM_CH(1), .IDLE_LIMIT(16)) u0 (
    .clk(clk), .rstn(rstn), .commit_valid(cv0), .halt_req(h0), .core_rstn(cr0),
    .cycle_cnt(cc0), .commit_cnt(cm0), .done(d0), .status(st0));
  run_controller #(.CYCLE_W(32), .MAX_CYCLES(0), .RST_HOLD(2), .NUM_CH(4), .IDLE_LIMIT(16)) u1 (
    .clk(clk), .rstn(rstn), .commit_valid(cv1), .halt_req(h1), .core_rstn(cr1),
    .cycle_cnt(cc1), .commit_cnt(cm1), .done(d1), .status(st1));
  run_controller #(.CYCLE_W(4), .MAX_CYCLES(0), .RST_HOLD(3), .NUM_CH(2), .IDLE_LIMIT(16)) u2 (
    .clk(clk), .rstn(rstn), .commit_valid(cv2), .halt_req(h2), .core_rstn(cr2),
    .cycle_cnt(cc2), .commit_cnt(cm2), .done(d2), .status(st2));

  // Per-instance configuration seen by the model.
  int     p_hold[3] = '{2, 2, 3};
  int     p_max[3]  = '{10, 0, 0};
  int     p_lim[3]  = '{16, 16, 16};
  longint p_cmax[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

  // Model state: edges seen since reset release, run counters and outcome.
  int     m_edges[3];
  bit     m_done[3];
  int     m_stat[3];
  longint m_cyc[3], m_com[3];
  int     m_idle[3];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int     dut;
    int     mask;
    int     ncyc;
    int     halt_at;
    int     e_done;
    int     e_stat;
    longint e_cyc;
    longint e_com;
  } vec_t;
  vec_t tv[5];

  function automatic int commits(input int d);
    case (d)
      0:       return int'(cv0);
      1:       return $countones(cv1);
      default: return $countones(cv2);
    endcase
  endfunction

  function automatic bit halt_of(input int d);
    case (d)
      0:       return h0;
      1:       return h1;
      default: return h2;
    endcase
  endfunction

  task automatic mreset();
    for (int d = 0; d < 3; d++) begin
      m_edges[d] = 0; m_done[d] = 0; m_stat[d] = 0;
      m_cyc[d] = 0; m_com[d] = 0; m_idle[d] = 0;
    end
  endtask

  // One rising edge of the reference behaviour for instance d.
  task automatic mstep(input int d);
    int pc;
    if (m_done[d]) return;
    if (m_edges[d] < p_hold[d]) begin
      m_edges[d]++;
      return;
    end
    pc = commits(d);
    m_cyc[d] = (m_cyc[d] + 1 > p_cmax[d]) ? p_cmax[d] : m_cyc[d] + 1;
    m_com[d] = (m_com[d] + pc > p_cmax[d]) ? p_cmax[d] : m_com[d] + pc;
    m_idle[d] = (pc != 0) ? 0 : ((m_idle[d] + 1 > p_lim[d]) ? p_lim[d] : m_idle[d] + 1);
    if (halt_of(d)) begin
      m_done[d] = 1; m_stat[d] = 1;
    end else if (p_max[d] != 0 && m_cyc[d] == p_max[d]) begin
      m_done[d] = 1; m_stat[d] = 2;
    end else if (HANG_EN && m_idle[d] == p_lim[d]) begin
      m_done[d] = 1; m_stat[d] = 3;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic get_act(input int d, output logic [63:0] cr, cc, cm, dn, st);
    case (d)
      0:       begin cr = 64'(cr0); cc = 64'(cc0); cm = 64'(cm0); dn = 64'(d0); st = 64'(st0); end
      1:       begin cr = 64'(cr1); cc = 64'(cc1); cm = 64'(cm1); dn = 64'(d1); st = 64'(st1); end
      default: begin cr = 64'(cr2); cc = 64'(cc2); cm = 64'(cm2); dn = 64'(d2); st = 64'(st2); end
    endcase
  endtask

  task automatic check_dut(input int d, input string tag);
    logic [63:0] cr, cc, cm, dn, st;
    get_act(d, cr, cc, cm, dn, st);
    chk($sformatf("%s u%0d core_rstn", tag, d), cr, 64'(m_edges[d] >= p_hold[d]));
    chk($sformatf("%s u%0d cycle_cnt", tag, d), cc, 64'(m_cyc[d]));
    chk($sformatf("%s u%0d commit_cnt", tag, d), cm, 64'(m_com[d]));
    chk($sformatf("%s u%0d done", tag, d), dn, 64'(m_done[d]));
    chk($sformatf("%s u%0d status", tag, d), st, 64'(m_stat[d]));
  endtask

  task automatic set_in(input int d, input int mask, input bit h);
    cv0 = 1'b0; cv1 = 4'b0; cv2 = 2'b0; h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
    case (d)
      0:       begin cv0 = mask[0];   h0 = h; end
      1:       begin cv1 = mask[3:0]; h1 = h; end
      default: begin cv2 = mask[1:0]; h2 = h; end
    endcase
  endtask

  // Inputs are changed at the falling edge; the model follows each rising edge.
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 3; d++) mstep(d);
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_dut(d, "edge");
  endtask

  // Asynchronous reset pulse, checked before any clock edge can act on it.
  task automatic do_reset();
    #2 rstn = 1'b0;
    mreset();
    #1;
    for (int d = 0; d < 3; d++) check_dut(d, "async_rst");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [63:0] cr, cc, cm, dn, st;
    int burst;
    set_in(0, 0, 1'b0);
    mreset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_dut(d, "por");
    rstn = 1'b1;

    tv[0] = '{dut: 0, mask: 1,     ncyc: 12, halt_at: 0,  e_done: 1, e_stat: 2, e_cyc: 10, e_com: 10};
    tv[1] = '{dut: 1, mask: 4'hB,  ncyc: 6,  halt_at: 6,  e_done: 1, e_stat: 1, e_cyc: 6,  e_com: 18};
    if (HANG_EN)
      tv[2] = '{dut: 1, mask: 0,   ncyc: 20, halt_at: 0,  e_done: 1, e_stat: 3, e_cyc: 16, e_com: 0};
    else
      tv[2] = '{dut: 1, mask: 0,   ncyc: 20, halt_at: 0,  e_done: 0, e_stat: 0, e_cyc: 22, e_com: 0};
    tv[3] = '{dut: 0, mask: 1,     ncyc: 10, halt_at: 10, e_done: 1, e_stat: 1, e_cyc: 10, e_com: 10};
    tv[4] = '{dut: 2, mask: 3,     ncyc: 20, halt_at: 0,  e_done: 0, e_stat: 0, e_cyc: 15, e_com: 15};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      set_in(0, 0, 1'b0);
      for (int k = 0; k < p_hold[tv[i].dut]; k++) tick();
      for (int k = 1; k <= tv[i].ncyc; k++) begin
        set_in(tv[i].dut, tv[i].mask, k == tv[i].halt_at);
        tick();
      end
      // Two more edges with the inputs idle: a finished run must stay frozen.
      set_in(0, 0, 1'b0);
      tick(); tick();
      get_act(tv[i].dut, cr, cc, cm, dn, st);
      chk($sformatf("vec%0d done", i), dn, 64'(tv[i].e_done));
      chk($sformatf("vec%0d status", i), st, 64'(tv[i].e_stat));
      chk($sformatf("vec%0d cycle_cnt", i), cc, 64'(tv[i].e_cyc));
      chk($sformatf("vec%0d commit_cnt", i), cm, 64'(tv[i].e_com));
    end

    // Reset in the middle of a run, then again after the run has finished.
    do_reset();
    set_in(0, 0, 1'b0);
    tick(); tick();
    set_in(0, 1, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    chk("midrun cycle_cnt before reset", 64'(cc0), 64'd5);
    #2 rstn = 1'b0;
    mreset();
    #1;
    chk("midrun rst core_rstn", 64'(cr0), 64'd0);
    chk("midrun rst cycle_cnt", 64'(cc0), 64'd0);
    chk("midrun rst commit_cnt", 64'(cm0), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    set_in(0, 0, 1'b0);
    tick();
    chk("rehold edge1 core_rstn", 64'(cr0), 64'd0);
    tick();
    chk("rehold edge2 core_rstn", 64'(cr0), 64'd1);
    set_in(0, 1, 1'b0);
    for (int k = 0; k < 10; k++) tick();
    chk("done before reset", 64'(d0), 64'd1);
    #2 rstn = 1'b0;
    mreset();
    #1;
    chk("done rst done", 64'(d0), 64'd0);
    chk("done rst status", 64'(st0), 64'd0);
    chk("done rst core_rstn", 64'(cr0), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Random stimulus with idle bursts, rare halts and occasional resets.
    burst = 0;
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 149) == 0 || (m_done[0] && m_done[1] && m_done[2])) do_reset();
      if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(5, 25);
      if (burst > 0) begin
        burst--;
        cv0 = 1'b0; cv1 = 4'b0; cv2 = 2'b0;
      end else begin
        cv0 = 1'($urandom);
        cv1 = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
        cv2 = 2'($urandom);
      end
      h0 = ($urandom_range(0, 59) == 0);
      h1 = ($urandom_range(0, 79) == 0);
      h2 = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/run_controller.md
# run_controller

Synthesizable run/stop controller for the CPU simulation and FPGA bring-up harness. It replaces the fixed reset pulse and fixed stop time with several parametrised features: a staged core reset release, a cycle budget, multi-port commit counting, halt detection and an optional hang watchdog. It sits between the top-level clock/reset and the CPU core. It drives the core's reset and reports a sticky completion status that the bench or a debug port samples.

## Interface
Parameters:
- CYCLE_W, 32: width of the cycle and commit counters.
- MAX_CYCLES, 10: run-cycle budget; 0 = unlimited.
- RST_HOLD, 2: number of clk rising edges after rstn release during which core_rstn stays low; must be ≥1.
- NUM_CH, 1: number of commit (retire) channels, 1..8.
- IDLE_LIMIT, 16: number of consecutive commit-free run cycles that declares a hang; must be ≥1.

Ports:
- clk, in, 1: single clock; all state is updated on the rising edge.
- rstn, in, 1: asynchronous active-low reset.
- commit_valid, in, NUM_CH: one bit per retire port, set when an instruction commits this cycle.
- halt_req, in, 1: core has retired ebreak/ecall; requests stop.
- core_rstn, out, 1: registered active-low reset to the core.
- cycle_cnt, out, CYCLE_W: number of RUN cycles elapsed.
- commit_cnt, out, CYCLE_W: total instructions committed.
- done, out, 1: sticky run-complete flag.
- status, out, 2: 00 RUNNING, 01 HALTED, 10 TIMEOUT, 11 HANG.

## Operation
- FSM states:
  - HOLD: hold counter runs; core_rstn=0; commit_valid and halt_req are ignored.
  - RUN: core_rstn=1; counters advance.
  - DONE: terminal state.
- HOLD→RUN on the rising edge where the hold counter reaches RST_HOLD−1. core_rstn is registered 1 on that same edge.
- In RUN, on each rising edge:
  - cycle_cnt += 1, saturating at all-ones.
  - commit_cnt += popcount(commit_valid), saturating at all-ones. Any addition that overflows clamps to all-ones.
- Stop conditions are evaluated on the same edge, with priority halt > timeout > hang:
  - HALTED: halt_req=1.
  - TIMEOUT: MAX_CYCLES≠0 and the next value of cycle_cnt equals MAX_CYCLES.
  - HANG: the idle counter reaches IDLE_LIMIT (only when the watchdog is compiled in).
- On any stop condition: go to DONE, set done=1, and latch status. Commits and the cycle presented on the stopping edge are still counted.
- DONE:
  - Counters freeze. done and status are held.
  - core_rstn stays 1 so core state remains inspectable.
  - commit_valid and halt_req are ignored.
  - The only exit is rstn assertion.
- Idle counter:
  - Cleared in HOLD and on any RUN cycle with a commit.
  - Otherwise increments by 1, saturating at IDLE_LIMIT.

## Timing
- Asynchronous reset (rstn=0), effective immediately without waiting for clk:
  - state=HOLD; hold and idle counters=0.
  - core_rstn=0, cycle_cnt=0, commit_cnt=0, done=0, status=00.
- Reset asserted mid-RUN or in DONE clears everything immediately. A new HOLD sequence starts after release.
- Reset release: core_rstn rises at the RST_HOLD-th rising edge after rstn goes high.
- With MAX_CYCLES=N: done rises at the Nth rising edge after core_rstn rises, and cycle_cnt=N at that edge.
- Latency halt_req→done is 1 edge (registered). All outputs are registered; there is no combinational input→output path.
- Halt and timeout on the same edge → status=01.

## Configuration
- RUN_CTRL_HANG_DET_EN defined: idle counter and HANG detection are present.
- RUN_CTRL_HANG_DET_EN undefined: no idle counter logic. status never reads 11, and IDLE_LIMIT is unused. All other behaviour is identical.

## Structure
- Shared package run_ctrl_pkg holds:
  - the state encoding (HOLD, RUN, DONE);
  - the status encoding (RUNNING, HALTED, TIMEOUT, HANG);
  - the counter width default.
- Sub-module commit_popcount: purely combinational, NUM_CH-bit input to a $clog2(NUM_CH+1)-bit count output. It is instantiated once.
- run_controller contains the FSM, the hold, cycle, commit and idle counters, and the output registers.

## Test plan
- Defaults; pulse rstn low then high; commit_valid=1 every RUN cycle → core_rstn rises on edge 2; done=1, status=10, cycle_cnt=10, commit_cnt=10.
- NUM_CH=4, MAX_CYCLES=0; commit_valid=4'b1011 for 5 cycles, then halt_req=1 → commit_cnt=18 including the halt cycle; status=01; done one edge after halt.
- Hang watchdog compiled in, IDLE_LIMIT=16, MAX_CYCLES=0, no commits → status=11 after 16 RUN cycles. With the watchdog compiled out, the same stimulus never sets done.
- halt_req asserted on the same edge where cycle_cnt reaches MAX_CYCLES=10 → status=01, cycle_cnt=10.
- rstn asserted asynchronously mid-RUN (cycle_cnt=5) and in DONE → all outputs return to reset values before the next clk edge; the HOLD sequence repeats after release.
- CYCLE_W=4, MAX_CYCLES=0, NUM_CH=2 with both channels committing every cycle → commit_cnt saturates at 15 and cycle_cnt saturates at 15 without wrapping.
